// File: rtl/timer_pkg.sv
// Shared types and constants for the CPU-visible timer block.
package timer_pkg;

    typedef enum logic {RUN, OVF} tmr_state_t;

    localparam logic [1:0] ADDR_DIV  = 2'd0;
    localparam logic [1:0] ADDR_TIMA = 2'd1;
    localparam logic [1:0] ADDR_TMA  = 2'd2;
    localparam logic [1:0] ADDR_TAC  = 2'd3;

    localparam int TAC_EN_BIT  = 2;
    localparam int TAC_SEL_LSB = 0;

endpackage

// File: rtl/timer_tap_edge.sv
// Selects the TIMA clock tap from the system counter and flags its falling edge.
module timer_tap_edge
    import timer_pkg::*;
#(
    parameter int CNT_WIDTH = 16,
    parameter int TAP0      = 9,
    parameter int TAP1      = 3,
    parameter int TAP2      = 5,
    parameter int TAP3      = 7
) (
    input  logic                 clk_in,
    input  logic                 Reset,
    input  logic [CNT_WIDTH-1:0] counter,
    input  logic [2:0]           tac,
    output logic                 tap_q,
    output logic                 inc
);

    logic tap_bit;
    logic tap;
    logic unused_cnt;

    always_comb begin
        tap_bit = 1'b0;
        case (tac[TAC_SEL_LSB +: 2])
            2'd0:    tap_bit = counter[TAP0];
            2'd1:    tap_bit = counter[TAP1];
            2'd2:    tap_bit = counter[TAP2];
            default: tap_bit = counter[TAP3];
        endcase
    end

    // Enable gates the tap, so disabling or reselecting can itself produce an edge.
    assign tap = tac[TAC_EN_BIT] & tap_bit;

    always_ff @(posedge clk_in) begin
        if (Reset) tap_q <= 1'b0;
        else       tap_q <= tap;
    end

    assign inc = tap_q & ~tap;

    // Only four counter bits feed the tap mux.
    assign unused_cnt = ^counter;

endmodule

// File: rtl/timer_ctrl.sv
// Timer controller: system counter, DIV/TIMA/TMA/TAC registers, overflow reload and IRQ.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int CNT_WIDTH = 16,
    parameter int TAP0      = 9,
    parameter int TAP1      = 3,
    parameter int TAP2      = 5,
    parameter int TAP3      = 7
) (
    input  logic       clk_in,
    input  logic       Reset,
    input  logic       ce,
    input  logic [1:0] addr,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    output logic       irq_timer
);

    logic [CNT_WIDTH-1:0] counter;
    logic [7:0]           tima, tima_nxt;
    logic [7:0]           tma;
    logic [2:0]           tac;
    tmr_state_t           state, state_nxt;
    logic                 irq_nxt;
    logic                 tap_q;
    logic                 inc;
    logic                 unused_tap;

    logic wr_div, wr_tima, wr_tma, wr_tac;
    assign wr_div  = wr_en && (addr == ADDR_DIV);
    assign wr_tima = wr_en && (addr == ADDR_TIMA);
    assign wr_tma  = wr_en && (addr == ADDR_TMA);
    assign wr_tac  = wr_en && (addr == ADDR_TAC);

    timer_tap_edge #(
        .CNT_WIDTH (CNT_WIDTH),
        .TAP0      (TAP0),
        .TAP1      (TAP1),
        .TAP2      (TAP2),
        .TAP3      (TAP3)
    ) u_tap (
        .clk_in  (clk_in),
        .Reset   (Reset),
        .counter (counter),
        .tac     (tac),
        .tap_q   (tap_q),
        .inc     (inc)
    );

    assign unused_tap = tap_q;

    // DIV write clears the whole counter and beats a same-cycle tick.
    always_ff @(posedge clk_in) begin
        if (Reset) begin
            counter <= '0;
            tma     <= 8'h00;
            tac     <= 3'b000;
        end else begin
            if (wr_div)  counter <= '0;
            else if (ce) counter <= counter + CNT_WIDTH'(1);
            if (wr_tma)  tma <= wr_data;
            if (wr_tac)  tac <= wr_data[2:0];
        end
    end

    always_comb begin
        state_nxt = state;
        tima_nxt  = tima;
        irq_nxt   = 1'b0;
        if (wr_tima) begin
            // CPU write beats increment, and aborts a pending reload.
            tima_nxt  = wr_data;
            state_nxt = RUN;
        end else begin
            case (state)
                RUN: begin
                    if (inc) begin
                        if (tima == 8'hFF) begin
                            tima_nxt  = 8'h00;
                            state_nxt = OVF;
                        end else begin
                            tima_nxt = tima + 8'd1;
                        end
                    end
                end
                OVF: begin
                    // Increments are swallowed while the zero value is held.
                    if (ce) begin
                        tima_nxt  = wr_tma ? wr_data : tma;
                        irq_nxt   = 1'b1;
                        state_nxt = RUN;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (Reset) begin
            state     <= RUN;
            tima      <= 8'h00;
            irq_timer <= 1'b0;
        end else begin
            state     <= state_nxt;
            tima      <= tima_nxt;
            irq_timer <= irq_nxt;
        end
    end

    always_comb begin
        rd_data = 8'h00;
        case (addr)
            ADDR_DIV:  rd_data = counter[15:8];
            ADDR_TIMA: rd_data = tima;
            ADDR_TMA:  rd_data = tma;
            default:   rd_data = {5'b11111, tac};
        endcase
    end

endmodule
